// File: rtl/magnitude_sqrt_pkg.sv
// Shared constants and FSM state type for the magnitude square-root stage.
package mag_pkg;

  localparam int MAG_IN_W  = 17;
  localparam int MAG_OUT_W = (MAG_IN_W + 1) / 2;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mag_sqrt_state_t;

endpackage

// File: rtl/magnitude_sqrt_if.sv
// Valid/ready handshake bundle: radicand in, root/remainder out.
interface magnitude_sqrt_if
  import mag_pkg::*;
#(
  parameter int IN_W  = MAG_IN_W,
  parameter int OUT_W = (IN_W + 1) / 2
) ();

  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_root;
  logic [OUT_W:0]   out_rem;
  logic             out_valid;
  logic             out_ready;

  // master is the surrounding pipeline (producer and consumer), slave is the sqrt block
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_root, out_rem, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_root, out_rem, out_valid
  );

endinterface

// File: rtl/magnitude_sqrt_step.sv
// One digit-recurrence step of the integer square root: resolves one root bit.
module sqrt_step
  import mag_pkg::*;
#(
  parameter int OUT_W = MAG_OUT_W
) (
  input  logic [OUT_W+1:0] i_rem,
  input  logic [OUT_W-1:0] i_root,
  input  logic [1:0]       i_bits,
  output logic [OUT_W+1:0] o_rem_next,
  output logic [OUT_W-1:0] o_root_next
);

  logic [OUT_W+3:0] w_shift;
  logic [OUT_W+1:0] w_trial;
  logic [OUT_W+1:0] w_diff;
  logic             w_ge;

  // Compare at full width so a wide shifted remainder can never alias low.
  assign w_shift = {i_rem, i_bits};
  assign w_trial = {i_root, 2'b01};
  assign w_ge    = (w_shift >= {2'b00, w_trial});
  assign w_diff  = w_shift[OUT_W+1:0] - w_trial;

  assign o_rem_next  = w_ge ? w_diff : w_shift[OUT_W+1:0];
  assign o_root_next = {i_root[OUT_W-2:0], w_ge};

endmodule

// File: rtl/magnitude_sqrt.sv
// Sequential integer square root, one result bit per enabled clock.
// Define MAG_SQRT_ROUND_EN to round out_root to nearest instead of floor.
module magnitude_sqrt
  import mag_pkg::*;
#(
  parameter int IN_W  = MAG_IN_W,
  parameter int OUT_W = (IN_W + 1) / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  magnitude_sqrt_if.slave  s_if
);

  localparam int RAD_W = 2 * OUT_W;
  localparam int CNT_W = $clog2(OUT_W + 1);

  mag_sqrt_state_t  r_state;
  logic [RAD_W-1:0] r_rad;
  logic [OUT_W-1:0] r_root;
  logic [OUT_W+1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_root;
  logic [OUT_W:0]   r_out_rem;

  logic [OUT_W+1:0] w_rem_next;
  logic [OUT_W-1:0] w_root_next;
  logic [OUT_W-1:0] w_final_root;

  sqrt_step #(.OUT_W(OUT_W)) u_step (
    .i_rem       (r_rem),
    .i_root      (r_root),
    .i_bits      (r_rad[RAD_W-1 -: 2]),
    .o_rem_next  (w_rem_next),
    .o_root_next (w_root_next)
  );

`ifdef MAG_SQRT_ROUND_EN
  // x - r^2 > r means sqrt(x) lies above r + 0.5, so round up (saturating).
  always_comb begin
    w_final_root = w_root_next;
    if ((w_rem_next > {2'b00, w_root_next}) && (w_root_next != '1))
      w_final_root = w_root_next + OUT_W'(1);
  end
`else
  assign w_final_root = w_root_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rad       <= '0;
      r_root      <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_root  <= '0;
      r_out_rem   <= '0;
    end else if (ena) begin
      case (r_state)
        IDLE: begin
          if (s_if.in_valid) begin
            r_rad      <= RAD_W'(s_if.in_data);
            r_root     <= '0;
            r_rem      <= '0;
            r_cnt      <= CNT_W'(OUT_W - 1);
            r_in_ready <= 1'b0;
            r_state    <= CALC;
          end
        end
        CALC: begin
          r_rad  <= {r_rad[RAD_W-3:0], 2'b00};
          r_root <= w_root_next;
          r_rem  <= w_rem_next;
          r_cnt  <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            r_out_root  <= w_final_root;
            r_out_rem   <= w_rem_next[OUT_W:0];
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (s_if.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_if.in_ready  = r_in_ready;
  assign s_if.out_valid = r_out_valid;
  assign s_if.out_root  = r_out_root;
  assign s_if.out_rem   = r_out_rem;

endmodule

// File: tb/tb_magnitude_sqrt.sv
// Self-checking bench for magnitude_sqrt: vector table, scoreboard, corner sequences.
module tb_magnitude_sqrt;
  import mag_pkg::*;

  typedef struct {
    logic [16:0] din;
    logic [8:0]  root;
    logic [9:0]  rem;
    logic [8:0]  rootRnd;
  } vec_t;

  typedef struct {
    logic [8:0] root;
    logic [9:0] rem;
  } exp_t;

  logic clk;
  logic rst;
  logic ena;
  int   total;
  int   bad;
  exp_t sb[$];
  vec_t vecs[12];

  magnitude_sqrt_if dif ();

  magnitude_sqrt dut (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .s_if (dif)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [8:0] pickRoot(input vec_t v);
`ifdef MAG_SQRT_ROUND_EN
    return v.rootRnd;
`else
    return v.root;
`endif
  endfunction

  // Independent brute-force model: largest r with r*r <= x.
  function automatic vec_t model(input logic [16:0] x);
    vec_t v;
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(x)) r++;
    v.din     = x;
    v.root    = 9'(r);
    v.rem     = 10'(int'(x) - r * r);
    v.rootRnd = (int'(x) - r * r > r) ? 9'(r + 1) : 9'(r);
    return v;
  endfunction

  task automatic waitReady();
    bit ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (dif.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL inReadyTimeout: got 0 expected 1");
    end
  endtask

  task automatic applyStimulus(input logic [16:0] d, input logic [8:0] er, input logic [9:0] erem);
    exp_t e;
    waitReady();
    e.root = er;
    e.rem  = erem;
    sb.push_back(e);
    dif.in_data  = d;
    dif.in_valid = 1'b1;
    @(posedge clk);
    #1 dif.in_valid = 1'b0;
  endtask

  task automatic checkOutput(input int expLat, input int hold);
    exp_t e;
    int   lat  = 1;
    bit   seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (dif.out_valid) begin
        seen = 1;
        break;
      end
      lat++;
    end
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboardEmpty: got 0 expected 1");
      return;
    end
    e = sb.pop_front();
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL outValidTimeout: got 0 expected 1");
      return;
    end
    if (expLat > 0) compare("latency", 32'(lat), 32'(expLat));
    compare("root", 32'(dif.out_root), 32'(e.root));
    compare("rem", 32'(dif.out_rem), 32'(e.rem));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      compare("holdValid", 32'(dif.out_valid), 32'd1);
      compare("holdRoot", 32'(dif.out_root), 32'(e.root));
      compare("holdRem", 32'(dif.out_rem), 32'(e.rem));
      compare("holdInReady", 32'(dif.in_ready), 32'd0);
    end
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1 dif.out_ready = 1'b0;
    compare("drainValid", 32'(dif.out_valid), 32'd0);
  endtask

  initial begin
    vec_t v;
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst   = 1'b1;
    ena   = 1'b1;
    dif.in_data   = '0;
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b0;

    vecs[0]  = '{17'd25,     9'd5,   10'd0,   9'd5};
    vecs[1]  = '{17'd24,     9'd4,   10'd8,   9'd5};
    vecs[2]  = '{17'd130050, 9'd360, 10'd450, 9'd361};
    vecs[3]  = '{17'd0,      9'd0,   10'd0,   9'd0};
    vecs[4]  = '{17'd1,      9'd1,   10'd0,   9'd1};
    vecs[5]  = '{17'd2,      9'd1,   10'd1,   9'd1};
    vecs[6]  = '{17'd3,      9'd1,   10'd2,   9'd2};
    vecs[7]  = '{17'd10000,  9'd100, 10'd0,   9'd100};
    vecs[8]  = '{17'd65535,  9'd255, 10'd510, 9'd256};
    vecs[9]  = '{17'd131071, 9'd362, 10'd27,  9'd362};
    vecs[10] = '{17'd9,      9'd3,   10'd0,   9'd3};
    vecs[11] = '{17'd99,     9'd9,   10'd18,  9'd10};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    compare("rstInReady", 32'(dif.in_ready), 32'd1);
    compare("rstOutValid", 32'(dif.out_valid), 32'd0);
    compare("rstRoot", 32'(dif.out_root), 32'd0);
    compare("rstRem", 32'(dif.out_rem), 32'd0);

    // 25 -> 5/0 with the nominal latency of 10 edges from acceptance.
    applyStimulus(17'd25, 9'd5, 10'd0);
    checkOutput(10, 0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].din, pickRoot(vecs[i]), vecs[i].rem);
      checkOutput(-1, 0);
    end

    // Zero radicand under 20 cycles of back-pressure.
    applyStimulus(17'd0, 9'd0, 10'd0);
    checkOutput(10, 20);

    // Reset landing on CALC edge T4 discards the computation.
    waitReady();
    dif.in_data  = 17'd130050;
    dif.in_valid = 1'b1;
    @(posedge clk);
    #1 dif.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 compare("busyInReady", 32'(dif.in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    compare("midRstInReady", 32'(dif.in_ready), 32'd1);
    compare("midRstOutValid", 32'(dif.out_valid), 32'd0);
    compare("midRstRoot", 32'(dif.out_root), 32'd0);
    compare("midRstRem", 32'(dif.out_rem), 32'd0);
    applyStimulus(17'd9, 9'd3, 10'd0);
    checkOutput(10, 0);

    // Enable dropped for 5 cycles mid-CALC stretches latency by exactly 5.
    applyStimulus(17'd10000, 9'd100, 10'd0);
    fork
      checkOutput(15, 0);
      begin
        repeat (2) @(posedge clk);
        #1 ena = 1'b0;
        repeat (5) @(posedge clk);
        #1 ena = 1'b1;
      end
    join

    for (int i = 0; i < 8; i++) begin
      v = model(17'($urandom_range(0, 131071)));
      applyStimulus(v.din, pickRoot(v), v.rem);
      checkOutput(10, 0);
    end

    compare("sbDrained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
